// File: rtl/clock_pkg.sv
// Shared encodings, field widths and limits for the clock timekeeping logic.
package clock_pkg;

  localparam int HR_W = 5;
  localparam int MS_W = 6;

  localparam logic [HR_W-1:0] HR_MAX = 5'd23;
  localparam logic [MS_W-1:0] MS_MAX = 6'd59;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2,
    MODE_SET_SEC = 2'd3
  } mode_t;

  // Hour increment; anything at or above the limit wraps to zero.
  function automatic logic [HR_W-1:0] inc_hr(input logic [HR_W-1:0] v);
    return (v >= HR_MAX) ? '0 : v + HR_W'(1);
  endfunction

  // Minute/second increment; anything at or above the limit wraps to zero.
  function automatic logic [MS_W-1:0] inc_ms(input logic [MS_W-1:0] v);
    return (v >= MS_MAX) ? '0 : v + MS_W'(1);
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Blink phase generator: phase toggles every BLINK_HALF enabled cycles.
// clr has priority and restarts the period with phase 0.
module blink_timer #(
  parameter int BLINK_HALF = 12_500_000
) (
  input  logic clk_50MHz,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic phase
);

  localparam int CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

  logic [CNT_W-1:0] cnt;

  // Half-period counter and phase flip-flop.
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (en) begin
      if (cnt == CNT_LAST) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Timekeeping sequencer: HH:MM:SS counting in RUN, button-driven field
// setting in the SET states, blink masking of the edited field and a
// one-cycle day_pulse on midnight rollover.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int BLINK_HALF = 12_500_000
) (
  input  logic            clk_50MHz,
  input  logic            rst,
  input  logic            tick_1hz,
  input  logic            btn_mode,
  input  logic            btn_inc,
  output logic [HR_W-1:0] hour,
  output logic [MS_W-1:0] minute,
  output logic [MS_W-1:0] second,
  output logic [1:0]      mode,
  output logic [2:0]      blank_mask,
  output logic            day_pulse
);

  mode_t           state;
  mode_t           state_next;
  logic [HR_W-1:0] hour_next;
  logic [MS_W-1:0] minute_next;
  logic [MS_W-1:0] second_next;
  logic            day_next;
  logic            tick_ok;
  logic            inc_ok;
  logic            phase;

  // A tick only counts in RUN; an inc only counts in SET and loses to btn_mode.
  assign tick_ok = tick_1hz && (state == MODE_RUN);
  assign inc_ok  = btn_inc && !btn_mode && (state != MODE_RUN);

  // Mode state register.
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) state <= MODE_RUN;
    else     state <= state_next;
  end

  // Mode sequencing: every btn_mode strobe advances one step around the ring.
  always_comb begin
    state_next = state;
    if (btn_mode) begin
      unique case (state)
        MODE_RUN:     state_next = MODE_SET_HR;
        MODE_SET_HR:  state_next = MODE_SET_MIN;
        MODE_SET_MIN: state_next = MODE_SET_SEC;
        MODE_SET_SEC: state_next = MODE_RUN;
        default:      state_next = MODE_RUN;
      endcase
    end
  end

  // Next field values: carry chain in RUN, single-field edit in SET.
  always_comb begin
    hour_next   = hour;
    minute_next = minute;
    second_next = second;
    day_next    = 1'b0;
    if (tick_ok) begin
      second_next = inc_ms(second);
      if (second >= MS_MAX) begin
        minute_next = inc_ms(minute);
        if (minute >= MS_MAX) begin
          hour_next = inc_hr(hour);
          day_next  = (hour >= HR_MAX);
        end
      end
    end else if (inc_ok) begin
      unique case (state)
        MODE_SET_HR:  hour_next   = inc_hr(hour);
        MODE_SET_MIN: minute_next = inc_ms(minute);
        MODE_SET_SEC: second_next = inc_ms(second);
        default:      ;
      endcase
    end
  end

  // Time field and day_pulse registers.
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      hour      <= '0;
      minute    <= '0;
      second    <= '0;
      day_pulse <= 1'b0;
    end else begin
      hour      <= hour_next;
      minute    <= minute_next;
      second    <= second_next;
      day_pulse <= day_next;
    end
  end

  // Blink runs only while setting; a mode change or an edit restarts it visible.
  blink_timer #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blink (
    .clk_50MHz(clk_50MHz),
    .rst      (rst),
    .en       (state != MODE_RUN),
    .clr      (btn_mode || inc_ok),
    .phase    (phase)
  );

  assign mode = state;

  // Blank mask is a decode of the mode and phase flops, one-hot on the edited field.
  always_comb begin
    blank_mask = 3'b000;
    if (phase) begin
      unique case (state)
        MODE_SET_HR:  blank_mask = 3'b100;
        MODE_SET_MIN: blank_mask = 3'b010;
        MODE_SET_SEC: blank_mask = 3'b001;
        default:      blank_mask = 3'b000;
      endcase
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl with a short blink period.
module tb_time_set_ctrl;

  logic       clk_50MHz = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [1:0] mode;
  logic [2:0] blank_mask;
  logic       day_pulse;

  time_set_ctrl #(.BLINK_HALF(4)) dut (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .tick_1hz  (tick_1hz),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .hour      (hour),
    .minute    (minute),
    .second    (second),
    .mode      (mode),
    .blank_mask(blank_mask),
    .day_pulse (day_pulse)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  typedef struct {
    string nm;
    int    due;
    bit    imm;
    int    h, mi, s, md, mask, day;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  event ev_probe;

  always @(posedge clk_50MHz) cyc <= cyc + 1;

  // Monitor: pops an expectation when its cycle's outputs are settled
  // (negedge) or, for immediate ones, when the driver probes mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_50MHz or ev_probe);
      if (q.size() > 0) begin
        e = q[0];
        if (e.imm || e.due == cyc) begin
          void'(q.pop_front());
          total++;
          if (int'(hour) != e.h || int'(minute) != e.mi || int'(second) != e.s ||
              int'(mode) != e.md || int'(blank_mask) != e.mask || int'(day_pulse) != e.day) begin
            bad++;
            $display("FAIL %s: got %0d:%0d:%0d mode=%0d mask=%b day=%0d, want %0d:%0d:%0d mode=%0d mask=%b day=%0d",
                     e.nm, hour, minute, second, mode, blank_mask, day_pulse,
                     e.h, e.mi, e.s, e.md, e.mask[2:0], e.day);
          end
        end
      end
    end
  end

  task automatic step(input bit t, input bit m, input bit i);
    tick_1hz = t;
    btn_mode = m;
    btn_inc  = i;
    @(posedge clk_50MHz);
    #1;
    tick_1hz = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic chk(input string nm, input int h, input int mi, input int s,
                     input int md, input int mask, input int day);
    exp_t e;
    e.nm = nm; e.due = cyc; e.imm = 1'b0;
    e.h = h; e.mi = mi; e.s = s; e.md = md; e.mask = mask; e.day = day;
    q.push_back(e);
  endtask

  task automatic chk_now(input string nm, input int h, input int mi, input int s,
                         input int md, input int mask, input int day);
    exp_t e;
    e.nm = nm; e.due = -1; e.imm = 1'b1;
    e.h = h; e.mi = mi; e.s = s; e.md = md; e.mask = mask; e.day = day;
    q.push_back(e);
    ->ev_probe;
    #0;
  endtask

  initial begin
    // Reset state, checked while reset is still asserted and after release.
    #1 rst = 1'b1;
    #2 chk_now("reset_async", 0, 0, 0, 0, 0, 0);
    @(posedge clk_50MHz);
    @(posedge clk_50MHz);
    #1 rst = 1'b0;
    step(0, 0, 0);
    chk("reset_idle", 0, 0, 0, 0, 0, 0);

    // 61 ticks in RUN: seconds wrap into minutes, no day_pulse, no blanking.
    for (int i = 1; i <= 61; i++) begin
      step(1, 0, 0);
      chk("run_tick", 0, i / 60, i % 60, 0, 0, 0);
    end
    step(0, 0, 1);
    chk("run_inc_ignored", 0, 1, 1, 0, 0, 0);

    // Preload 23:59:58 through the set states.
    step(0, 1, 0);
    chk("enter_set_hr", 0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 23; i++) step(0, 0, 1);
    chk("set_hr_23", 23, 1, 1, 1, 0, 0);
    step(0, 1, 0);
    for (int i = 0; i < 58; i++) step(0, 0, 1);
    chk("set_min_59", 23, 59, 1, 2, 0, 0);
    step(0, 1, 0);
    for (int i = 0; i < 57; i++) step(0, 0, 1);
    chk("set_sec_58", 23, 59, 58, 3, 0, 0);
    step(0, 1, 0);
    chk("back_to_run", 23, 59, 58, 0, 0, 0);
    step(1, 0, 0);
    chk("tick_235959", 23, 59, 59, 0, 0, 0);
    step(1, 0, 0);
    chk("midnight_pulse", 0, 0, 0, 0, 0, 1);
    step(0, 0, 0);
    chk("pulse_one_cycle", 0, 0, 0, 0, 0, 0);

    // Hour edit wraps at 24; ticks are dropped in SET.
    step(0, 1, 0);
    for (int i = 0; i < 25; i++) step(0, 0, 1);
    chk("hr_wrap_25", 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      chk("set_tick_frozen", 1, 0, 0, 1, 0, 0);
    end
    step(1, 0, 0);
    chk("hr_blink_on", 1, 0, 0, 1, 3'b100, 0);

    // Blink in SET_MIN, restart on inc, then SET_SEC.
    step(0, 1, 0);
    chk("min_enter", 1, 0, 0, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin step(0, 0, 0); chk("min_phase0", 1, 0, 0, 2, 0, 0); end
    for (int i = 0; i < 4; i++) begin step(0, 0, 0); chk("min_phase1", 1, 0, 0, 2, 3'b010, 0); end
    step(0, 0, 1);
    chk("min_inc_show", 1, 1, 0, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin step(0, 0, 0); chk("min_inc_hold", 1, 1, 0, 2, 0, 0); end
    step(0, 0, 0);
    chk("min_inc_blank", 1, 1, 0, 2, 3'b010, 0);
    step(0, 1, 0);
    chk("sec_enter", 1, 1, 0, 3, 0, 0);
    for (int i = 0; i < 3; i++) begin step(0, 0, 0); chk("sec_phase0", 1, 1, 0, 3, 0, 0); end
    step(0, 0, 0);
    chk("sec_phase1", 1, 1, 0, 3, 3'b001, 0);

    // Simultaneous strobes.
    step(0, 1, 1);
    chk("mode_beats_inc", 1, 1, 0, 0, 0, 0);
    step(1, 1, 0);
    chk("tick_and_mode", 1, 1, 1, 1, 0, 0);

    // Reach SET_MIN at 12:34:56, then reset asynchronously.
    for (int i = 0; i < 11; i++) step(0, 0, 1);
    step(0, 1, 0);
    for (int i = 0; i < 33; i++) step(0, 0, 1);
    step(0, 1, 0);
    for (int i = 0; i < 55; i++) step(0, 0, 1);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    chk("preload_123456", 12, 34, 56, 2, 0, 0);
    @(negedge clk_50MHz);
    #2 rst = 1'b1;
    #1 chk_now("reset_mid_set", 0, 0, 0, 0, 0, 0);
    @(posedge clk_50MHz);
    #1 rst = 1'b0;
    step(1, 0, 0);
    chk("after_reset_tick", 0, 0, 1, 0, 0, 0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
